if_prefetch_queue: RTL

Instruction-fetch front end of the 5-stage pipeline. It generates the fetch PC and requests instructions from the instruction cache. Returned words are buffered in a small prefetch queue, and the queue drives the IF/ID pipeline register that feeds decode. It consumes the hazard unit's stall_ID, nop_IF and branch_PC_contral, and supplies Instraction_pype/PC_pype to decode.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/if_prefetch_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the 5-stage core front end.
package pipe_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // One prefetch queue slot: the fetch address and the word returned for it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head entry is always visible on dout.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next pointer/occupancy: flush wins, otherwise push and pop act independently.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write port.
    // NOTE: the data array has no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

    // The owner must never push into a full queue unless it pops in the same cycle.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop && !flush) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: fetch PC, I-cache request, prefetch queue and IF/ID register.
module if_prefetch_queue
    import pipe_pkg::XLEN;
    import pipe_pkg::fetch_entry_t;
#(
    parameter  logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter  int          DEPTH    = 2,
    parameter  logic [31:0] NOP_INSN = pipe_pkg::NOP_INSN,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] iaddr,
    output logic            ireq,
    input  logic            iready_n,
    input  logic [XLEN-1:0] idata,
    input  logic            branch_PC_contral,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall_ID,
    input  logic            nop_IF,
    output logic [XLEN-1:0] Instraction_pype,
    output logic [XLEN-1:0] PC_pype,
    output logic            inst_valid,
    output logic [CW-1:0]   q_count
);

    logic [XLEN-1:0] fpc_q,   fpc_d;
    logic [XLEN-1:0] insn_q,  insn_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic            valid_q, valid_d;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         q_empty;
    logic         q_has_room;
    logic         pop;
    logic         accept;

    assign q_empty    = (q_count == '0);
    assign q_has_room = (q_count < CW'(DEPTH));

    // A redirect, a stall or a bubble all keep the head in the queue.
    assign pop    = !stall_ID && !branch_PC_contral && !nop_IF && !q_empty;
    // A full queue can still fetch when the head leaves in the same cycle.
    assign ireq   = rst && !branch_PC_contral && (q_has_room || pop);
    assign iaddr  = fpc_q;
    assign accept = ireq && !iready_n;

    assign push_entry = '{pc: fpc_q, insn: idata};

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (accept),
        .pop   (pop),
        .flush (branch_PC_contral),
        .din   (push_entry),
        .dout  (head),
        .count (q_count)
    );

    // Next fetch PC: redirect to the word-aligned target, else advance on each accepted word.
    always_comb begin
        fpc_d = fpc_q;
        if (branch_PC_contral)  fpc_d = {branch_target[XLEN-1:2], 2'b00};
        else if (accept)        fpc_d = fpc_q + 32'd4;
    end

    // IF/ID next state in priority order: redirect, stall, bubble, queue head, idle bubble.
    always_comb begin
        insn_d  = insn_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (branch_PC_contral) begin
            insn_d  = NOP_INSN;
            valid_d = 1'b0;
        end else if (stall_ID) begin
            // hold
        end else if (nop_IF || q_empty) begin
            insn_d  = NOP_INSN;
            valid_d = 1'b0;
        end else begin
            insn_d  = head.insn;
            pc_d    = head.pc;
            valid_d = 1'b1;
        end
    end

    // Fetch PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q   <= RESET_PC;
            insn_q  <= NOP_INSN;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            fpc_q   <= fpc_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign Instraction_pype = insn_q;
    assign PC_pype          = pc_q;
    assign inst_valid       = valid_q;

endmodule
